fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch stage for the single-cycle ARM core, directly upstream of the instruction memory. It holds the PC and drives a word index to imem, which returns the instruction combinationally in the same cycle. Each fetched instruction is captured with its PC into a small prefetch buffer. The buffer feeds decode over a valid/ready handshake, and a branch redirect flushes it.

Parameters:
RESET_PC, 32'h0000_0000, byte address fetched first after reset; must be word-aligned.
IMEM_WORDS, 64, number of valid imem words; word index >= IMEM_WORDS is out of range.
BUF_DEPTH, 2, prefetch buffer entries; power of two, >= 2.

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
imem_a  out  32  word index to imem, equal to pc[31:2] zero-extended
imem_rd  in  32  instruction word from imem, valid combinationally in the same cycle
br_valid  in  1  redirect request from execute
br_target  in  32  redirect byte address
out_valid  out  1  buffer head is valid
out_ready  in  1  decode accepts the head
out_instr  out  32  head instruction
out_pc  out  32  head byte PC
out_pc8  out  32  out_pc + 8 (architectural PC read value)
fault  out  1  sticky fetch fault

Behaviour:
- Reset (async assert, sync release):
  - pc = RESET_PC; buffer empty.
  - out_valid = 0, fault = 0.
  - out_instr, out_pc and out_pc8 are 0.
  - imem_a = RESET_PC>>2.
- Fetch condition, per cycle: fetch = !fault && !br_valid && (count < BUF_DEPTH || pop) && in_range.
  - pop = out_valid && out_ready.
  - in_range = pc[31:2] < IMEM_WORDS.
- On fetch: push {pc, imem_rd} at the clock edge, and pc <= pc + 4 (32-bit, wraps modulo 2^32).
- Latency: the first instruction is presented with out_valid=1 in the cycle after the first post-reset edge. Steady-state throughput is 1 instruction per cycle while out_ready=1.
- Full buffer: push and pop in the same cycle are allowed and count is unchanged. If full with no pop, pc holds and no push occurs.
- Handshake rules:
  - out_instr, out_pc and out_pc8 stay stable while out_valid && !out_ready.
  - out_valid never drops without a pop or a redirect.
- Redirect (br_valid=1, highest priority):
  - The buffer is flushed at the edge.
  - pc <= {br_target[31:2], 2'b00}.
  - No push that cycle; any simultaneous pop is still counted as consumed by decode.
  - out_valid = 0 in the following cycle.
- Misaligned redirect (br_target[1:0] != 0): the redirect is still performed (flush, aligned pc) and fault is set at the same edge.
- Out-of-range pc (pc[31:2] >= IMEM_WORDS):
  - No push.
  - fault is set at the next edge.
  - Entries already buffered continue to drain normally.
- Fault is sticky:
  - Once set, fetching stops until reset; br_valid is ignored except for flushing the buffer.
  - Only reset clears fault.
- Reset mid-operation: everything returns immediately (asynchronously) to the reset values; in-flight entries are lost.
- out_pc8 = out_pc + 8, computed combinationally from the head entry and truncated to 32 bits.

Decomposition:
- Package arm_fetch_pkg:
  - INSTR_W = 32, PC_INCR = 32'd4, PC_READ_OFS = 32'd8.
  - typedef fetch_entry_t = packed struct {pc[31:0], instr[31:0]}.
- Sub-module fetch_buf:
  - Parameterised BUF_DEPTH FIFO of fetch_entry_t.
  - Ports: push, pop, flush, full, empty, head.
  - Pointer wrap uses the index width plus one extra bit for the full/empty distinction; flush has priority over push.
- fetch_unit contains the pc register, the fetch/fault control and out_pc8.

Test Plan:
- Reset stream: imem word0=32'hE04F000F, word1=32'hE3A01001, out_ready=1, release reset -> cycle 1: out_instr=E04F000F, out_pc=0, out_pc8=8; cycle 2: out_instr=E3A01001, out_pc=4.
- Backpressure: out_ready=0 for 5 cycles -> buffer fills with 2 entries; pc frozen at 8; imem_a=2; head stays 32'hE04F000F; resuming out_ready -> pcs 0, 4, 8 with no gaps or duplicates.
- Redirect with a full buffer and simultaneous pop: br_valid=1, br_target=32'h30 -> next cycle out_valid=0; following cycle out_pc=32'h30, imem_a was 12.
- Misaligned redirect: br_target=32'h22 -> fault=1 next cycle; pc=32'h20; no further pushes; fault holds until reset_n is pulsed low.
- Out of range: IMEM_WORDS=64, run straight-line from 0 with out_ready=1 -> the last out_pc is 32'hFC; then fault=1 and out_valid=0 after the drain.
- Async reset mid-stream: assert reset_n low between clock edges -> out_valid=0, fault=0 and imem_a=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/arm_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   INSTR_W      instruction word width
//   PC_INCR      sequential fetch step in bytes
//   PC_READ_OFS  offset from the fetch PC to the architectural PC read value
//   fetch_entry_t  one prefetch buffer entry: fetch PC plus the fetched word
package arm_fetch_pkg;

  localparam int          INSTR_W     = 32;
  localparam logic [31:0] PC_INCR     = 32'd4;
  localparam logic [31:0] PC_READ_OFS = 32'd8;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Prefetch buffer: a small FIFO of fetch_entry_t between fetch and decode.
//   clk, reset_n  clock and asynchronous active-low reset
//   push, din     write din at the tail (caller guarantees !full or pop)
//   pop           drop the head entry (caller guarantees !empty)
//   flush         discard every entry; wins over push and pop
//   full, empty   occupancy flags
//   head          oldest entry; contents are meaningless while empty
module fetch_buf
  import arm_fetch_pkg::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  // Pointers carry one extra wrap bit so equal indices can be told apart
  // as either empty (same lap) or full (one lap apart).
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  fetch_entry_t mem [BUF_DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone decide
  // validity, and leaving the array out of reset keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage. Holds the PC, reads imem combinationally, and
// queues {pc, instr} into a prefetch buffer that decode drains over a
// valid/ready handshake. A branch redirect flushes the buffer.
//   clk, reset_n          clock and asynchronous active-low reset
//   imem_a / imem_rd      word index to imem / word returned same cycle
//   br_valid, br_target   redirect request and byte target from execute
//   out_valid, out_ready  head-valid / decode-accept handshake
//   out_instr, out_pc     head instruction and its byte PC (0 while empty)
//   out_pc8               out_pc + 8, the architectural PC read value
//   fault                 sticky: misaligned redirect or out-of-range PC
module fetch_unit
  import arm_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 64,
  parameter int          BUF_DEPTH  = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic [31:0]        imem_a,
  input  logic [INSTR_W-1:0] imem_rd,
  input  logic               br_valid,
  input  logic [31:0]        br_target,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [31:0]        out_pc,
  output logic [31:0]        out_pc8,
  output logic               fault
);

  localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS);

  logic [31:0]  pc;
  logic         in_range;
  logic         pop;
  logic         fetch;
  logic         buf_full;
  logic         buf_empty;
  fetch_entry_t buf_head;
  fetch_entry_t push_entry;

  assign imem_a     = {2'b00, pc[31:2]};
  assign in_range   = (imem_a < IMEM_LIMIT);
  assign out_valid  = !buf_empty;
  assign pop        = out_valid && out_ready;
  // A slot freed by this cycle's pop can be refilled at the same edge.
  assign fetch      = !fault && !br_valid && (!buf_full || pop) && in_range;
  assign push_entry = '{pc: pc, instr: imem_rd};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc    <= RESET_PC;
      fault <= 1'b0;
    end else if (br_valid) begin
      // Once faulted, a redirect only flushes the buffer; pc stays put.
      if (!fault) begin
        pc <= {br_target[31:2], 2'b00};
        if (br_target[1:0] != 2'b00) fault <= 1'b1;
      end
    end else if (!fault) begin
      if (!in_range)  fault <= 1'b1;
      else if (fetch) pc    <= pc + PC_INCR;
    end
  end

  fetch_buf #(
    .BUF_DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fetch),
    .pop     (pop),
    .flush   (br_valid),
    .din     (push_entry),
    .full    (buf_full),
    .empty   (buf_empty),
    .head    (buf_head)
  );

  // Head fields read as zero while empty so the unreset storage never leaks.
  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    out_instr = '0;
    out_pc    = '0;
    out_pc8   = '0;
    if (out_valid) begin
      out_instr = buf_head.instr;
      out_pc    = buf_head.pc;
      out_pc8   = buf_head.pc + PC_READ_OFS;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// traffic, compared every cycle against a queue-based reference model.
module tb_fetch_unit;
  import arm_fetch_pkg::*;

  localparam int WORDS = 64;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] imem_a;
  logic [31:0] imem_rd;
  logic        br_valid = 1'b0;
  logic [31:0] br_target = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc8;
  logic        fault;

  logic [31:0] mem [WORDS];
  int checks = 0;
  int errors = 0;

  // Reference model state
  fetch_entry_t q[$];
  logic [31:0]  m_pc;
  logic         m_fault;

  always #5 clk = ~clk;

  assign imem_rd = (imem_a < 32'(WORDS)) ? mem[imem_a[5:0]] : 32'hDEAD_BEEF;

  fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_WORDS (WORDS),
    .BUF_DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .imem_a    (imem_a),
    .imem_rd   (imem_rd),
    .br_valid  (br_valid),
    .br_target (br_target),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .out_pc8   (out_pc8),
    .fault     (fault)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string phase);
    bit v;
    v = (q.size() > 0);
    check({phase, ".out_valid"}, {31'b0, out_valid}, {31'b0, v});
    check({phase, ".out_instr"}, out_instr, v ? q[0].instr : 32'h0);
    check({phase, ".out_pc"},    out_pc,    v ? q[0].pc    : 32'h0);
    check({phase, ".out_pc8"},   out_pc8,   v ? q[0].pc + 32'd8 : 32'h0);
    check({phase, ".fault"},     {31'b0, fault}, {31'b0, m_fault});
    check({phase, ".imem_a"},    imem_a,    m_pc >> 2);
  endtask

  // One clock edge of the specified behaviour, expressed on a queue.
  task automatic model_edge(input logic brv, input logic [31:0] brt, input logic rdy);
    fetch_entry_t e;
    if (q.size() > 0 && rdy) void'(q.pop_front());
    if (brv) begin
      q.delete();
      if (!m_fault) begin
        m_pc = brt & 32'hFFFF_FFFC;
        if (brt[1:0] != 2'b00) m_fault = 1'b1;
      end
    end else if (!m_fault) begin
      if ((m_pc >> 2) >= 32'(WORDS)) m_fault = 1'b1;
      else if (q.size() < DEPTH) begin
        e.pc    = m_pc;
        e.instr = mem[m_pc[7:2]];
        q.push_back(e);
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  // Called at posedge+1: drive inputs, check at posedge+2, advance one edge.
  task automatic cycle(input logic brv, input logic [31:0] brt, input logic rdy);
    br_valid  = brv;
    br_target = brt;
    out_ready = rdy;
    #1;
    check_outputs("cyc");
    model_edge(brv, brt, rdy);
    @(posedge clk);
    #1;
  endtask

  // Asserts reset between edges and checks the values appear at once.
  task automatic do_reset();
    reset_n   = 1'b0;
    br_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    q.delete();
    m_pc    = 32'h0;
    m_fault = 1'b0;
    check_outputs("rst");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    logic        brv;
    logic [31:0] brt;
    foreach (mem[i]) mem[i] = $urandom;
    mem[0] = 32'hE04F000F;
    mem[1] = 32'hE3A01001;

    // Reset stream
    do_reset();
    cycle(1'b0, 32'h0, 1'b1);
    check("plan.first_instr", out_instr, 32'hE04F000F);
    check("plan.first_pc8", out_pc8, 32'h8);
    cycle(1'b0, 32'h0, 1'b1);
    check("plan.second_instr", out_instr, 32'hE3A01001);
    check("plan.second_pc", out_pc, 32'h4);
    repeat (3) cycle(1'b0, 32'h0, 1'b1);

    // Backpressure, then resume (mid-stream async reset first)
    do_reset();
    repeat (5) cycle(1'b0, 32'h0, 1'b0);
    check("plan.bp_imem_a", imem_a, 32'd2);
    check("plan.bp_head", out_instr, 32'hE04F000F);
    repeat (5) cycle(1'b0, 32'h0, 1'b1);

    // Redirect with a full buffer and a simultaneous pop
    do_reset();
    repeat (3) cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b1, 32'h30, 1'b1);
    check("plan.redir_valid", {31'b0, out_valid}, 32'h0);
    check("plan.redir_imem_a", imem_a, 32'd12);
    cycle(1'b0, 32'h0, 1'b1);
    check("plan.redir_pc", out_pc, 32'h30);
    repeat (2) cycle(1'b0, 32'h0, 1'b1);

    // Misaligned redirect: fault sticks, redirects ignored afterwards
    cycle(1'b1, 32'h22, 1'b1);
    check("plan.mis_fault", {31'b0, fault}, 32'h1);
    check("plan.mis_imem_a", imem_a, 32'd8);
    cycle(1'b0, 32'h0, 1'b1);
    cycle(1'b1, 32'h40, 1'b1);
    repeat (3) cycle(1'b0, 32'h0, 1'b1);
    check("plan.mis_hold", {31'b0, fault}, 32'h1);

    // Out of range after straight-line fetch
    do_reset();
    check("plan.rst_clears_fault", {31'b0, fault}, 32'h0);
    repeat (64) cycle(1'b0, 32'h0, 1'b1);
    check("plan.last_pc", out_pc, 32'hFC);
    repeat (2) cycle(1'b0, 32'h0, 1'b1);
    check("plan.oor_fault", {31'b0, fault}, 32'h1);
    check("plan.oor_valid", {31'b0, out_valid}, 32'h0);

    // Random traffic with occasional redirects and resets
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 59) == 0) do_reset();
      brv = ($urandom_range(0, 11) == 0);
      brt = 32'($urandom_range(0, 72)) << 2;
      if ($urandom_range(0, 5) == 0) brt[1:0] = 2'($urandom_range(1, 3));
      cycle(brv, brt, $urandom_range(0, 3) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
